// File: rtl/eth_rx_frame_fifo_if.sv
// eth_rx_frame_fifo_if
//   8-bit AXI-Stream bundle used for both sides of the receive frame FIFO.
//   Signals: tdata[7:0], tvalid, tready, tlast, tuser.
//   master : drives tdata/tvalid/tlast/tuser, samples tready.
//   slave  : samples tdata/tvalid/tlast/tuser, drives tready.
interface eth_rx_frame_fifo_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo
//   Store-and-forward receive frame buffer behind the GMII MAC rx AXI-Stream.
//   Bytes are always accepted (no input backpressure); a frame only becomes
//   visible on the output once its last byte has been stored. Frames that do
//   not fit are dropped (status_overflow); frames ending with tuser=1 pulse
//   status_bad_frame.
//   Optional feature macro: ETH_RX_FIFO_DROP_BAD_FRAME_EN
//     defined   : bad frames are rewound and never forwarded; m_axis.tuser = 0.
//     undefined : bad frames are forwarded with tuser=1 on their last byte.
// Ports
//   clk, rst          : rx_clk, asynchronous active-high reset
//   s_axis (slave)    : input stream from the MAC; tready tied high
//   m_axis (master)   : buffered output stream, back-pressurable
//   status_overflow   : 1-cycle pulse, frame dropped for lack of space
//   status_bad_frame  : 1-cycle pulse, frame ended with tuser=1
//   status_good_frame : 1-cycle pulse, frame committed
//   status_fill       : committed bytes not yet loaded into the output register
module eth_rx_frame_fifo #(
  parameter  int unsigned DEPTH      = 4096,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  eth_rx_frame_fifo_if.slave    s_axis,
  eth_rx_frame_fifo_if.master   m_axis,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame,
  output logic [ADDR_WIDTH:0]   status_fill
);

  typedef logic [ADDR_WIDTH:0] ptr_t;
  localparam ptr_t FULL_DIFF = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic {ST_PASS, ST_DROP} state_t;

  state_t     state_q, state_d;
  ptr_t       wr_cur_q, wr_cur_d;
  ptr_t       wr_commit_q, wr_commit_d;
  ptr_t       commit_rd_q;
  ptr_t       rd_ptr_q;
  logic       full, empty, wr_en, load, tuser_w;
  logic       ovf_d, bad_d, good_d;
  logic       ovf_q, bad_q, good_q;
  logic [9:0] mem [DEPTH];
  logic [7:0] m_data_q;
  logic       m_valid_q, m_last_q, m_user_q;

  assign s_axis.tready = 1'b1;

  assign full  = (wr_cur_q - rd_ptr_q) == FULL_DIFF;
  // Reader sees the commit pointer one cycle late; this gives the two-cycle
  // commit-to-tvalid latency while keeping a single output register.
  assign empty = (rd_ptr_q == commit_rd_q);
  assign load  = (!m_valid_q || m_axis.tready) && !empty;

`ifdef ETH_RX_FIFO_DROP_BAD_FRAME_EN
  // Bad frames never commit, so the stored flag is constant zero.
  assign tuser_w = 1'b0;
`else
  assign tuser_w = s_axis.tlast & s_axis.tuser;
`endif

  always_comb begin
    state_d     = state_q;
    wr_cur_d    = wr_cur_q;
    wr_commit_d = wr_commit_q;
    wr_en       = 1'b0;
    ovf_d       = 1'b0;
    bad_d       = 1'b0;
    good_d      = 1'b0;
    if (s_axis.tvalid) begin
      unique case (state_q)
        ST_PASS: begin
          if (full) begin
            if (s_axis.tlast) begin
              wr_cur_d = wr_commit_q;
              ovf_d    = 1'b1;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            wr_en    = 1'b1;
            wr_cur_d = wr_cur_q + 1'b1;
            if (s_axis.tlast) begin
              if (s_axis.tuser) begin
                bad_d = 1'b1;
`ifdef ETH_RX_FIFO_DROP_BAD_FRAME_EN
                wr_cur_d = wr_commit_q;
`else
                wr_commit_d = wr_cur_q + 1'b1;
`endif
              end else begin
                good_d      = 1'b1;
                wr_commit_d = wr_cur_q + 1'b1;
              end
            end
          end
        end
        ST_DROP: begin
          if (s_axis.tlast) begin
            state_d  = ST_PASS;
            wr_cur_d = wr_commit_q;
            ovf_d    = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PASS;
      wr_cur_q    <= '0;
      wr_commit_q <= '0;
      commit_rd_q <= '0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      good_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cur_q    <= wr_cur_d;
      wr_commit_q <= wr_commit_d;
      commit_rd_q <= wr_commit_q;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      good_q      <= good_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cur_q[ADDR_WIDTH-1:0]] <= {s_axis.tlast, tuser_w, s_axis.tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= 1'b0;
    end else if (load) begin
      rd_ptr_q  <= rd_ptr_q + 1'b1;
      m_valid_q <= 1'b1;
      {m_last_q, m_user_q, m_data_q} <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end else if (m_axis.tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_axis.tvalid     = m_valid_q;
  assign m_axis.tdata      = m_data_q;
  assign m_axis.tlast      = m_last_q;
  assign m_axis.tuser      = m_user_q;
  assign status_overflow   = ovf_q;
  assign status_bad_frame  = bad_q;
  assign status_good_frame = good_q;
  assign status_fill       = wr_commit_q - rd_ptr_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo
//   Randomized bench for eth_rx_frame_fifo (DEPTH=128). The reference model is
//   a queue of expected output words plus a schedule of expected status pulses,
//   filled from the frame-level rules: a frame is dropped when it does not fit,
//   bad frames are dropped or forwarded depending on
//   ETH_RX_FIFO_DROP_BAD_FRAME_EN, everything else is forwarded in order.
module tb_eth_rx_frame_fifo;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          status_overflow, status_bad_frame, status_good_frame;
  logic [AW:0]   status_fill;

  eth_rx_frame_fifo_if s_if();
  eth_rx_frame_fifo_if m_if();

  eth_rx_frame_fifo #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .status_overflow   (status_overflow),
    .status_bad_frame  (status_bad_frame),
    .status_good_frame (status_good_frame),
    .status_fill       (status_fill)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [2:0] code; } pulse_t;  // code = {ovf, bad, good}
  logic [9:0] exp_q[$];   // {tlast, tuser, tdata}
  pulse_t     pulse_q[$];
  int         rdy_mode = 1; // 0: low, 1: high, 2: toggle, 3: random

  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b0;
        1:       m_if.tready = 1'b1;
        2:       m_if.tready = ~m_if.tready;
        default: m_if.tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output scoreboard, stall-stability and per-cycle pulse checks.
  logic        prev_stall = 1'b0;
  logic [10:0] prev_out;
  always @(negedge clk) begin
    logic [2:0] exp_p;
    logic [9:0] w;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      exp_p = 3'b000;
      if (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) exp_p = pulse_q.pop_front().code;
      n_cmp++;
      if ({status_overflow, status_bad_frame, status_good_frame} !== exp_p) begin
        n_err++;
        $display("FAIL status_pulses cyc=%0d got=%b want=%b", cyc,
                 {status_overflow, status_bad_frame, status_good_frame}, exp_p);
      end
      if (prev_stall) begin
        n_cmp++;
        if ({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata} !== prev_out) begin
          n_err++;
          $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc,
                   {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata}, prev_out);
        end
      end
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_output cyc=%0d got=%h want=none", cyc,
                   {m_if.tlast, m_if.tuser, m_if.tdata});
        end else begin
          w = exp_q.pop_front();
          if ({m_if.tlast, m_if.tuser, m_if.tdata} !== w) begin
            n_err++;
            $display("FAIL output_word cyc=%0d got=%h want=%h", cyc,
                     {m_if.tlast, m_if.tuser, m_if.tdata}, w);
          end
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_out   = {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata};
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Drive one frame; record its fate in the model. keep=1 leaves the bus so the
  // next frame can follow without an idle cycle.
  task automatic send_frame(input int len, input bit user, input bit drop,
                            input int gap_max, input bit keep, output int last_cyc);
    logic [9:0] fr[$];
    logic [7:0] d;
    bit         last;
    pulse_t     p;
    for (int i = 0; i < len; i++) begin
      if (i > 0 && gap_max > 0)
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; s_if.tvalid = 1'b0; end
      @(posedge clk); #1;
      d    = 8'($urandom);
      last = (i == len - 1);
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = last;
      s_if.tuser  = last ? user : 1'($urandom);
      fr.push_back({last, last & user, d});
    end
    last_cyc = cyc;
    p.cyc    = cyc + 1;
    if (drop) begin
      p.code = 3'b100;
    end else if (user) begin
      p.code = 3'b010;
`ifndef ETH_RX_FIFO_DROP_BAD_FRAME_EN
      foreach (fr[j]) exp_q.push_back(fr[j]);
`endif
    end else begin
      p.code = 3'b001;
      foreach (fr[j]) exp_q.push_back(fr[j]);
    end
    pulse_q.push_back(p);
    if (!keep) begin
      @(posedge clk); #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  // Conservative room test: outstanding expected bytes bound the ring occupancy.
  task automatic wait_room(input int len, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() + len <= DEPTH) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Exact fit rule while tready is held low: one committed byte sits in the
  // output register and no longer occupies the ring.
  function automatic bit fits_stalled(input int len);
    int occ = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
    return (occ + len) <= DEPTH;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser, status_overflow, status_bad_frame,
         status_good_frame, status_fill} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b%h%b%b%b%b%b fill=%0d want=all_zero", m_if.tvalid,
               m_if.tdata, m_if.tlast, m_if.tuser, status_overflow, status_bad_frame,
               status_good_frame, status_fill);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m_if.tvalid, status_fill} !== '0) begin
      n_err++;
      $display("FAIL post_reset_idle got=%b/%0d want=0/0", m_if.tvalid, status_fill);
    end
  endtask

  task automatic drain_and_check(input string name);
    bit ok;
    rdy_mode = 1;
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_drain got=%0d_left want=0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({m_if.tvalid, status_fill} !== '0) begin
      n_err++;
      $display("FAIL %s_idle got=valid%b_fill%0d want=valid0_fill0", name, m_if.tvalid, status_fill);
    end
  endtask

  task automatic test_single_frame();
    int k;
    int gaps;
    rdy_mode = 1;
    send_frame(64, 1'b0, 1'b0, 0, 1'b0, k);
    while (cyc < k + 2) @(negedge clk);
    n_cmp++;
    if (m_if.tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early got=%b want=0", m_if.tvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (m_if.tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL latency_rise got=%b want=1", m_if.tvalid);
    end
    gaps = 0;
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      if (m_if.tvalid !== 1'b1) gaps++;
    end
    n_cmp++;
    if (gaps !== 0) begin
      n_err++;
      $display("FAIL single_stream_gaps got=%0d want=0", gaps);
    end
    drain_and_check("single");
  endtask

  task automatic test_bad_frame();
    int k;
    int exp_fill;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send_frame(60, 1'b1, 1'b0, 0, 1'b0, k);
    repeat (4) @(negedge clk);
    exp_fill = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
    n_cmp++;
    if (status_fill !== exp_fill[AW:0]) begin
      n_err++;
      $display("FAIL bad_frame_fill got=%0d want=%0d", status_fill, exp_fill);
    end
    send_frame(64, 1'b0, 1'b0, 0, 1'b0, k);
    drain_and_check("bad_frame");
  endtask

  task automatic test_overflow();
    int k;
    int lens[6] = '{40, 40, 40, 9, 1, 130};
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    foreach (lens[i]) send_frame(lens[i], 1'b0, !fits_stalled(lens[i]), 0, 1'b0, k);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (status_fill !== DEPTH[AW:0]) begin
      n_err++;
      $display("FAIL overflow_fill_full got=%0d want=%0d", status_fill, DEPTH);
    end
    drain_and_check("overflow");
    // Longer than the storage: dropped even while the reader is running.
    send_frame(200, 1'b0, 1'b1, 0, 1'b0, k);
    send_frame(20, 1'b0, 1'b0, 0, 1'b0, k);
    drain_and_check("oversize");
  endtask

  task automatic test_backpressure();
    int k;
    rdy_mode = 2;
    send_frame(64, 1'b0, 1'b0, 0, 1'b1, k);
    send_frame(64, 1'b0, 1'b0, 0, 1'b0, k);
    drain_and_check("backpressure");
  endtask

  task automatic test_back_to_back();
    int k;
    int gaps;
    bool_wait: begin end
    rdy_mode = 1;
    gaps = 0;
    fork
      begin
        send_frame(64, 1'b0, 1'b0, 0, 1'b1, k);
        send_frame(64, 1'b0, 1'b0, 0, 1'b0, k);
      end
      begin
        int w = 0;
        @(negedge clk);
        while (m_if.tvalid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        for (int i = 0; i < 128; i++) begin
          if (i > 0) @(negedge clk);
          if (m_if.tvalid !== 1'b1) gaps++;
        end
      end
    join
    n_cmp++;
    if (gaps !== 0) begin
      n_err++;
      $display("FAIL back_to_back_gaps got=%0d want=0", gaps);
    end
    drain_and_check("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    int k;
    rdy_mode = 0;
    send_frame(20, 1'b0, 1'b0, 0, 1'b0, k);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      s_if.tvalid = 1'b1; s_if.tdata = 8'($urandom); s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    end
    @(posedge clk); #3;
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    exp_q.delete();
    pulse_q.delete();
    #1;
    n_cmp++;
    if (m_if.tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async_valid got=%b want=0", m_if.tvalid);
    end
    @(negedge clk);
    n_cmp++;
    if ({m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser, status_overflow, status_bad_frame,
         status_good_frame, status_fill} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs got=%b%h fill=%0d want=all_zero", m_if.tvalid,
               m_if.tdata, status_fill);
    end
    @(posedge clk); #1; rst = 1'b0;
    // The rest of the interrupted frame is seen as a fresh 34-byte frame.
    send_frame(34, 1'b0, 1'b0, 0, 1'b1, k);
    send_frame(64, 1'b0, 1'b0, 0, 1'b0, k);
    drain_and_check("reset_mid");
  endtask

  task automatic test_pointer_wrap();
    int k;
    bit ok;
    rdy_mode = 1;
    for (int f = 0; f < 200; f++) begin
      wait_room(61, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL wrap_room frame=%0d got=%0d_pending want<=%0d", f, exp_q.size(), DEPTH - 61);
      end else begin
        send_frame(61, 1'b0, 1'b0, 0, 1'b0, k);
      end
    end
    drain_and_check("wrap");
  endtask

  task automatic test_random();
    int k;
    int len;
    bit ok;
    rdy_mode = 3;
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, 90);
      wait_room(len, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL random_room frame=%0d got=%0d_pending want<=%0d", f, exp_q.size(), DEPTH - len);
      end else begin
        send_frame(len, ($urandom_range(0, 3) == 0), 1'b0, $urandom_range(0, 3), 1'b0, k);
      end
    end
    drain_and_check("random");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bad_frame();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_pointer_wrap();
    test_random();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pulse_q.size() !== 0) begin
      n_err++;
      $display("FAIL pending_pulses got=%0d want=0", pulse_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
